// File: rtl/datain_dealer.sv
// rtl/datain_dealer.sv - load-return unit: tracks outstanding loads, captures read data, formats WB value
module datain_dealer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [1:0]  req_ea,
  input  logic [31:0] req_rt,
  input  logic [4:0]  req_dest,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        resp_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LWL = 6'd34;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_LBU = 6'd36;
  localparam logic [5:0] OP_LHU = 6'd37;
  localparam logic [5:0] OP_LWR = 6'd38;

  logic [5:0]       op_q   [DEPTH];
  logic [5:0]       op_d   [DEPTH];
  logic [1:0]       ea_q   [DEPTH];
  logic [1:0]       ea_d   [DEPTH];
  logic [31:0]      rt_q   [DEPTH];
  logic [31:0]      rt_d   [DEPTH];
  logic [4:0]       dest_q [DEPTH];
  logic [4:0]       dest_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d, pend_q, pend_d;
  logic             err_q, err_d;

  logic push, retire, fill_en;

  function automatic logic [31:0] fmt(input logic [5:0] op, input logic [1:0] ea,
                                      input logic [31:0] m, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = m[{ea, 3'b000} +: 8];
    h = ea[1] ? m[31:16] : m[15:0];
    res = 32'h0;
    case (op)
      OP_LB:  res = {{24{b[7]}}, b};
      OP_LBU: res = {24'h0, b};
      OP_LH:  res = {{16{h[15]}}, h};
      OP_LHU: res = {16'h0, h};
      OP_LW:  res = m;
      OP_LWL: begin
        case (ea)
          2'd0:    res = {m[7:0],  r[23:0]};
          2'd1:    res = {m[15:0], r[15:0]};
          2'd2:    res = {m[23:0], r[7:0]};
          default: res = m;
        endcase
      end
      OP_LWR: begin
        case (ea)
          2'd0:    res = m;
          2'd1:    res = {r[31:24], m[31:8]};
          2'd2:    res = {r[31:16], m[31:16]};
          default: res = {r[31:8],  m[31:24]};
        endcase
      end
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  assign req_ready = (count_q < CW'(DEPTH));
  assign wb_valid  = (count_q != '0) & filled_q[head_q];
  assign wb_data   = wb_valid ? fmt(op_q[head_q], ea_q[head_q], data_q[head_q], rt_q[head_q]) : 32'h0;
  assign wb_dest   = wb_valid ? dest_q[head_q] : 5'h0;
  assign resp_err  = err_q;

  // pend_q counts accepted-but-unfilled entries; only registered state gates a fill
  assign push    = req_valid & req_ready;
  assign retire  = wb_valid & wb_ready;
  assign fill_en = mem_rvalid & (pend_q != '0);

  always_comb begin
    op_d     = op_q;
    ea_d     = ea_q;
    rt_d     = rt_q;
    dest_d   = dest_q;
    data_d   = data_q;
    filled_d = filled_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    err_d    = err_q;
    if (push) begin
      op_d[tail_q]     = req_opcode;
      ea_d[tail_q]     = req_ea;
      rt_d[tail_q]     = req_rt;
      dest_d[tail_q]   = req_dest;
      filled_d[tail_q] = 1'b0;
      tail_d           = tail_q + PW'(1);
    end
    if (fill_en) begin
      data_d[fill_q]   = mem_rdata;
      filled_d[fill_q] = 1'b1;
      fill_d           = fill_q + PW'(1);
    end else if (mem_rvalid) begin
      err_d = 1'b1;
    end
    if (retire) begin
      filled_d[head_q] = 1'b0;
      head_d           = head_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(retire);
    pend_d  = pend_q + CW'(push) - CW'(fill_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        ea_q[i]   <= '0;
        rt_q[i]   <= '0;
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      ea_q     <= ea_d;
      rt_q     <= rt_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
      filled_q <= filled_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_datain_dealer.sv
// tb/tb_datain_dealer.sv - directed table-driven bench for datain_dealer
module tb_datain_dealer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [1:0]  req_ea;
  logic [31:0] req_rt;
  logic [4:0]  req_dest;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        resp_err;

  int n_pass = 0;
  int n_total = 0;

  datain_dealer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_ea(req_ea), .req_rt(req_rt), .req_dest(req_dest),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  ea;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [5:0] op, input logic [1:0] ea,
                         input logic [31:0] rt, input logic [4:0] dest);
    req_valid  = v;
    req_opcode = op;
    req_ea     = ea;
    req_rt     = rt;
    req_dest   = dest;
  endtask

  initial begin
    vecs[0]  = '{6'd32, 2'd3, 32'h0,        32'h80000000, 32'hFFFFFF80};
    vecs[1]  = '{6'd36, 2'd3, 32'h0,        32'h80000000, 32'h00000080};
    vecs[2]  = '{6'd34, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344};
    vecs[3]  = '{6'd38, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'h11AABBCC};
    vecs[4]  = '{6'd33, 2'd2, 32'h0,        32'h80010000, 32'hFFFF8001};
    vecs[5]  = '{6'd37, 2'd1, 32'h0,        32'h1234F00F, 32'h0000F00F};
    vecs[6]  = '{6'd35, 2'd2, 32'h55555555, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[7]  = '{6'd34, 2'd0, 32'h11223344, 32'hAABBCCDD, 32'hDD223344};
    vecs[8]  = '{6'd34, 2'd2, 32'h11223344, 32'hAABBCCDD, 32'hBBCCDD44};
    vecs[9]  = '{6'd34, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD};
    vecs[10] = '{6'd38, 2'd0, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD};
    vecs[11] = '{6'd38, 2'd2, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB};
    vecs[12] = '{6'd38, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'h112233AA};
    vecs[13] = '{6'd32, 2'd1, 32'h0,        32'h00007F00, 32'h0000007F};
    vecs[14] = '{6'd43, 2'd0, 32'hFFFFFFFF, 32'h12345678, 32'h00000000};

    rst = 1'b1;
    set_req(1'b0, 6'd0, 2'd0, 32'h0, 5'd0);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    wb_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_wb_data", wb_data, 32'h0);
    chk("reset_wb_dest", 32'(wb_dest), 32'd0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);

    // single load per vector: accept, respond next cycle, check, retire
    for (int i = 0; i < 15; i++) begin
      set_req(1'b1, vecs[i].op, vecs[i].ea, vecs[i].rt, 5'(i + 1));
      tick();
      req_valid  = 1'b0;
      req_rt     = 32'hDEADDEAD;
      mem_rvalid = 1'b1;
      mem_rdata  = vecs[i].rdata;
      chk($sformatf("vec%0d_not_yet_valid", i), 32'(wb_valid), 32'd0);
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      chk($sformatf("vec%0d_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), wb_data, vecs[i].exp);
      chk($sformatf("vec%0d_dest", i), 32'(wb_dest), 32'(i + 1));
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk($sformatf("vec%0d_retired", i), 32'(wb_valid), 32'd0);
    end

    // fill both slots, hold WB, then full + retire + request
    set_req(1'b1, 6'd35, 2'd0, 32'h0, 5'd1);
    tick();
    set_req(1'b1, 6'd35, 2'd0, 32'h0, 5'd2);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA0A0A0A0;
    tick();
    chk("full_req_ready", 32'(req_ready), 32'd0);
    set_req(1'b0, 6'd35, 2'd0, 32'h0, 5'd3);
    mem_rdata = 32'hB0B0B0B0;
    tick();
    mem_rvalid = 1'b0;
    chk("full_head_valid", 32'(wb_valid), 32'd1);
    chk("full_head_data", wb_data, 32'hA0A0A0A0);
    tick();
    chk("hold_head_data", wb_data, 32'hA0A0A0A0);
    chk("hold_head_dest", 32'(wb_dest), 32'd1);
    wb_ready  = 1'b1;
    req_valid = 1'b1;
    tick();
    chk("after_retire_req_ready", 32'(req_ready), 32'd1);
    chk("second_data", wb_data, 32'hB0B0B0B0);
    chk("second_dest", 32'(wb_dest), 32'd2);
    tick();
    req_valid = 1'b0;
    wb_ready  = 1'b0;
    chk("third_pending_no_valid", 32'(wb_valid), 32'd0);
    chk("third_count_ready", 32'(req_ready), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hC0C0C0C0;
    tick();
    mem_rvalid = 1'b0;
    chk("third_data", wb_data, 32'hC0C0C0C0);
    chk("third_dest", 32'(wb_dest), 32'd3);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("drained", 32'(wb_valid), 32'd0);
    chk("drained_ready", 32'(req_ready), 32'd1);

    // back-to-back responses with wb_ready held high
    wb_ready = 1'b1;
    set_req(1'b1, 6'd36, 2'd0, 32'h0, 5'd7);
    tick();
    set_req(1'b1, 6'd36, 2'd1, 32'h0, 5'd8);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00001122;
    tick();
    req_valid = 1'b0;
    mem_rdata = 32'h00003344;
    chk("stream_x_data", wb_data, 32'h00000022);
    tick();
    mem_rvalid = 1'b0;
    chk("stream_y_valid", 32'(wb_valid), 32'd1);
    chk("stream_y_data", wb_data, 32'h00000033);
    tick();
    wb_ready = 1'b0;
    chk("stream_done", 32'(wb_valid), 32'd0);
    chk("stream_no_err", 32'(resp_err), 32'd0);

    // orphan response sets sticky error
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    chk("orphan_err", 32'(resp_err), 32'd1);
    chk("orphan_no_valid", 32'(wb_valid), 32'd0);
    tick();
    chk("err_sticky", 32'(resp_err), 32'd1);

    // reset with one filled and one pending entry
    set_req(1'b1, 6'd35, 2'd0, 32'h0, 5'd9);
    tick();
    set_req(1'b1, 6'd35, 2'd0, 32'h0, 5'd10);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h99999999;
    tick();
    req_valid  = 1'b0;
    mem_rvalid = 1'b0;
    chk("pre_rst_valid", 32'(wb_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_err_clear", 32'(resp_err), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    tick();
    mem_rvalid = 1'b0;
    chk("stale_resp_err", 32'(resp_err), 32'd1);
    chk("stale_no_valid", 32'(wb_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
